// File: rtl/text_overlay_ctrl_pkg.sv
// text_overlay_ctrl_pkg: font character codes, glyph/window geometry and converter states
package text_overlay_ctrl_pkg;
    localparam logic [4:0] CH_D     = 5'd10;
    localparam logic [4:0] CH_T     = 5'd11;
    localparam logic [4:0] CH_E     = 5'd12;
    localparam logic [4:0] CH_M     = 5'd13;
    localparam logic [4:0] CH_P     = 5'd14;
    localparam logic [4:0] CH_BLANK = 5'd15;
    localparam logic [4:0] CH_A     = 5'd16;
    localparam logic [4:0] CH_U     = 5'd17;
    localparam logic [4:0] CH_C     = 5'd18;
    localparam logic [4:0] CH_L     = 5'd19;
    localparam logic [4:0] CH_S     = 5'd20;
    localparam logic [4:0] CH_R     = 5'd25;
    localparam int GLYPH_W  = 8;
    localparam int GLYPH_H  = 16;
    localparam int WIN_COLS = 16;
    localparam int WIN_ROWS = 2;
    localparam int WIN_W    = GLYPH_W * WIN_COLS;
    localparam int WIN_H    = GLYPH_H * WIN_ROWS;
    typedef enum logic [1:0] {IDLE, CONV, WR} conv_state_t;
endpackage

// File: rtl/text_overlay_ctrl_if.sv
// text_overlay_ctrl_if: system-controller side of the overlay
//   wr_en/wr_row/wr_col/wr_code : character buffer write port
//   temp_valid/temp_in/temp_ready : temperature update handshake
interface text_overlay_ctrl_if;
    logic       wr_en;
    logic       wr_row;
    logic [3:0] wr_col;
    logic [4:0] wr_code;
    logic       temp_valid;
    logic [6:0] temp_in;
    logic       temp_ready;
    modport master (output wr_en, wr_row, wr_col, wr_code, temp_valid, temp_in, input temp_ready);
    modport slave  (input wr_en, wr_row, wr_col, wr_code, temp_valid, temp_in, output temp_ready);
endinterface

// File: rtl/text_overlay_ctrl_temp_bin2dig.sv
// text_overlay_ctrl_temp_bin2dig: binary temperature to two digit codes by repeated subtraction
//   temp_valid/temp_in/temp_ready : update handshake, transfer on valid & ready
//   dig_we                        : one-cycle strobe writing tens_code/units_code
module text_overlay_ctrl_temp_bin2dig
    import text_overlay_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       temp_valid,
    input  logic [6:0] temp_in,
    output logic       temp_ready,
    output logic       dig_we,
    output logic [4:0] tens_code,
    output logic [4:0] units_code
);
    conv_state_t state, state_nx;
    logic [6:0] acc;
    logic [3:0] tens;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            tens  <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && temp_valid) begin
                acc  <= (temp_in > 7'd99) ? 7'd99 : temp_in;
                tens <= '0;
            end else if (state == CONV && acc >= 7'd10) begin
                acc  <= acc - 7'd10;
                tens <= tens + 4'd1;
            end
        end
    end
    always_comb begin
        state_nx = state;
        state_nx = (state == IDLE) ? (temp_valid ? CONV : IDLE) :
                   (state == CONV) ? ((acc >= 7'd10) ? CONV : WR) : IDLE;
    end
    assign temp_ready = (state == IDLE);
    assign dig_we     = (state == WR);
    // leading zero of the tens digit is shown as a blank cell
    assign tens_code  = (tens == 4'd0) ? CH_BLANK : {1'b0, tens};
    assign units_code = {1'b0, acc[3:0]};
endmodule

// File: rtl/text_overlay_ctrl.sv
// text_overlay_ctrl: 2x16 character buffer and 2-stage font ROM pipeline producing a text pixel
//   pix_tick/pixel_x/pixel_y/video_on : pixel timing inputs, pipeline advances on pix_tick
//   character_select/rom_addr/rom_col : registered font ROM address, rom_bit is its pixel return
//   text_on                           : registered text pixel, 2 pix_ticks after the coordinate
//   bus                               : buffer write port and temperature handshake
module text_overlay_ctrl
    import text_overlay_ctrl_pkg::*;
#(
    parameter logic [9:0] X0       = 10'd256,
    parameter logic [9:0] Y0       = 10'd208,
    parameter logic       TEMP_ROW = 1'b1,
    parameter logic [3:0] TEMP_COL = 4'd6
)(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pix_tick,
    input  logic [9:0]          pixel_x,
    input  logic [9:0]          pixel_y,
    input  logic                video_on,
    output logic [4:0]          character_select,
    output logic [3:0]          rom_addr,
    output logic [2:0]          rom_col,
    input  logic                rom_bit,
    output logic                text_on,
    text_overlay_ctrl_if.slave  bus
);
    logic [4:0] cells [WIN_ROWS][WIN_COLS];
    logic [9:0] dx, dy;
    logic       in_win, win_d1, dig_we;
    logic [4:0] tens_code, units_code;
    // unsigned wrap makes coordinates left of / above the window fail the range test
    assign dx     = pixel_x - X0;
    assign dy     = pixel_y - Y0;
    assign in_win = (dx < 10'(WIN_W)) && (dy < 10'(WIN_H));
    text_overlay_ctrl_temp_bin2dig u_conv (
        .clk        (clk),
        .rst_n      (rst_n),
        .temp_valid (bus.temp_valid),
        .temp_in    (bus.temp_in),
        .temp_ready (bus.temp_ready),
        .dig_we     (dig_we),
        .tens_code  (tens_code),
        .units_code (units_code)
    );
    // converter writes come last so they win a same-cell collision
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < WIN_ROWS; r++)
                for (int c = 0; c < WIN_COLS; c++)
                    cells[r][c] <= CH_BLANK;
        end else begin
            if (bus.wr_en)
                cells[bus.wr_row][bus.wr_col] <= bus.wr_code;
            if (dig_we) begin
                cells[TEMP_ROW][TEMP_COL]        <= tens_code;
                cells[TEMP_ROW][TEMP_COL + 4'd1] <= units_code;
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            character_select <= CH_BLANK;
            rom_addr         <= '0;
            rom_col          <= '0;
            win_d1           <= 1'b0;
            text_on          <= 1'b0;
        end else if (pix_tick) begin
            character_select <= in_win ? cells[dy[4]][dx[6:3]] : CH_BLANK;
            rom_addr         <= dy[3:0];
            rom_col          <= ~dx[2:0];
            win_d1           <= in_win & video_on;
            text_on          <= rom_bit & win_d1;
        end
    end
endmodule

// File: tb/tb_text_overlay_ctrl.sv
// tb_text_overlay_ctrl: randomized scoreboard bench with a behavioural buffer/font model
module tb_text_overlay_ctrl;
    localparam int X0 = 256;
    localparam int Y0 = 208;

    typedef struct packed {
        logic [4:0] cs;
        logic [3:0] a;
        logic [2:0] c;
    } s1_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pix_tick = 1'b0;
    logic [9:0] pixel_x = '0;
    logic [9:0] pixel_y = '0;
    logic       video_on = 1'b0;
    logic [4:0] character_select;
    logic [3:0] rom_addr;
    logic [2:0] rom_col;
    logic       rom_bit;
    logic       text_on;
    logic [7:0] rom_row;

    text_overlay_ctrl_if bus();

    text_overlay_ctrl dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .pix_tick         (pix_tick),
        .pixel_x          (pixel_x),
        .pixel_y          (pixel_y),
        .video_on         (video_on),
        .character_select (character_select),
        .rom_addr         (rom_addr),
        .rom_col          (rom_col),
        .rom_bit          (rom_bit),
        .text_on          (text_on),
        .bus              (bus)
    );

    always #5 clk = ~clk;

    // stand-in font: blank codes render nothing, 'T' row 1 is 11111110, others a fixed pattern
    function automatic logic [7:0] glyph(input logic [4:0] code, input logic [3:0] r);
        if (code == 5'd15 || (code >= 5'd21 && code != 5'd25)) return 8'h00;
        if (code == 5'd11 && r == 4'd1) return 8'hFE;
        return 8'((int'(code) * 37 + int'(r) * 91 + 13) & 255);
    endfunction

    assign rom_row = glyph(character_select, rom_addr);
    assign rom_bit = rom_row[rom_col];

    int   errors = 0;
    int   checks = 0;
    logic [4:0] mbuf [2][16];
    s1_t  s1q[$];
    bit   tq[$];
    int   bq[$];
    int   busy = 0;
    bit   hold_ok = 0;
    logic [12:0] last;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: pops expectations whenever the DUT presents a result
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            busy = 0;
            hold_ok = 0;
        end else begin
            if (!bus.temp_ready) busy++;
            else if (busy > 0) begin
                if (bq.size() == 0) chk("busy_unexpected", busy, 0);
                else chk("busy_len", busy, bq.pop_front());
                busy = 0;
            end
            if (pix_tick) begin
                if (s1q.size() == 0) chk("s1_unexpected", 1, 0);
                else begin
                    s1_t e;
                    e = s1q.pop_front();
                    chk("char_sel", int'(character_select), int'(e.cs));
                    chk("rom_addr", int'(rom_addr), int'(e.a));
                    chk("rom_col", int'(rom_col), int'(e.c));
                end
                if (tq.size() >= 2) chk("text_on", int'(text_on), int'(tq.pop_front()));
                last = {character_select, rom_addr, rom_col, text_on};
                hold_ok = 1;
            end else if (hold_ok) begin
                chk("hold", int'({character_select, rom_addr, rom_col, text_on}), int'(last));
            end
        end
    end

    task automatic model_reset();
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 16; c++)
                mbuf[r][c] = 5'd15;
        s1q.delete();
        tq.delete();
        bq.delete();
        tq.push_back(1'b0);
    endtask

    task automatic check_reset_outputs();
        chk("rst_char_sel", int'(character_select), 15);
        chk("rst_rom_addr", int'(rom_addr), 0);
        chk("rst_rom_col", int'(rom_col), 0);
        chk("rst_text_on", int'(text_on), 0);
        chk("rst_temp_ready", int'(bus.temp_ready), 1);
    endtask

    task automatic pix(input int x, input int y, input bit v);
        int ix, iy;
        bit inw;
        logic [4:0] code;
        logic [7:0] g;
        @(negedge clk);
        pixel_x = 10'(x);
        pixel_y = 10'(y);
        video_on = v;
        pix_tick = 1'b1;
        ix = x - X0;
        iy = y - Y0;
        inw = ix >= 0 && ix < 128 && iy >= 0 && iy < 32;
        code = inw ? mbuf[iy / 16][ix / 8] : 5'd15;
        g = glyph(code, 4'(y % 16));
        s1q.push_back('{code, 4'(y % 16), 3'(7 - x % 8)});
        tq.push_back(inw && v ? g[7 - x % 8] : 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            pix_tick = 1'b0;
        end
    endtask

    task automatic scan_cell(input int r, input int c, input bit v);
        pix(X0 + c * 8 + int'($urandom_range(0, 7)), Y0 + r * 16 + int'($urandom_range(0, 15)), v);
    endtask

    task automatic scan_all();
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 16; c++)
                scan_cell(r, c, 1'b1);
        idle(1);
    endtask

    task automatic wr(input int r, input int c, input int code);
        @(negedge clk);
        pix_tick = 1'b0;
        bus.wr_en = 1'b1;
        bus.wr_row = 1'(r);
        bus.wr_col = 4'(c);
        bus.wr_code = 5'(code);
        mbuf[r][c] = 5'(code);
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!bus.temp_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.temp_ready) chk("ready_timeout", 0, 1);
    endtask

    task automatic send_temp(input int t);
        int v;
        v = t > 99 ? 99 : t;
        wait_ready();
        @(negedge clk);
        pix_tick = 1'b0;
        bus.temp_valid = 1'b1;
        bus.temp_in = 7'(t);
        bq.push_back(v / 10 + 2);
        @(negedge clk);
        bus.temp_valid = 1'b0;
    endtask

    task automatic finish_temp(input int t);
        int v;
        v = t > 99 ? 99 : t;
        wait_ready();
        mbuf[1][6] = (v / 10 == 0) ? 5'd15 : 5'(v / 10);
        mbuf[1][7] = 5'(v % 10);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.wr_en = 1'b0;
        bus.wr_row = 1'b0;
        bus.wr_col = '0;
        bus.wr_code = '0;
        bus.temp_valid = 1'b0;
        bus.temp_in = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        // blank window plus out-of-window points including left/top wrap-around
        scan_all();
        pix(5, Y0 + 3, 1);
        pix(X0 - 1, Y0 + 3, 1);
        pix(X0 + 128, Y0 + 3, 1);
        pix(X0 + 10, Y0 - 1, 1);
        pix(X0 + 10, Y0 + 32, 1);
        idle(1);
        // 'T' at (0,0), pixel (X0+2, Y0+1), then a 3-cycle pix_tick stall mid-glyph
        wr(0, 0, 11);
        pix(X0 + 2, Y0 + 1, 1);
        pix(X0 + 3, Y0 + 1, 1);
        idle(3);
        pix(X0 + 4, Y0 + 1, 1);
        pix(X0 + 7, Y0 + 1, 0);
        idle(3);
        // conversions: 47, 5, saturating 120 with an ignored pulse during CONV
        send_temp(47);
        finish_temp(47);
        scan_cell(1, 6, 1);
        scan_cell(1, 7, 1);
        send_temp(5);
        finish_temp(5);
        scan_cell(1, 6, 1);
        scan_cell(1, 7, 1);
        send_temp(120);
        @(negedge clk);
        bus.temp_valid = 1'b1;
        bus.temp_in = 7'd33;
        @(negedge clk);
        bus.temp_valid = 1'b0;
        finish_temp(120);
        scan_all();
        // external write colliding with the converter write of the tens cell
        send_temp(62);
        repeat (7) @(negedge clk);
        bus.wr_en = 1'b1;
        bus.wr_row = 1'b1;
        bus.wr_col = 4'd6;
        bus.wr_code = 5'd2;
        mbuf[1][6] = 5'd2;
        @(negedge clk);
        bus.wr_en = 1'b0;
        finish_temp(62);
        scan_cell(1, 6, 1);
        scan_cell(1, 7, 1);
        idle(1);
        // randomized mix
        repeat (60) begin
            case ($urandom_range(0, 3))
                0: wr(int'($urandom_range(0, 1)), int'($urandom_range(0, 15)), int'($urandom_range(0, 31)));
                1: begin
                    int t;
                    t = int'($urandom_range(0, 127));
                    send_temp(t);
                    finish_temp(t);
                end
                2: repeat (8) begin
                    if ($urandom_range(0, 3) == 0)
                        pix(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), 1'($urandom));
                    else
                        scan_cell(int'($urandom_range(0, 1)), int'($urandom_range(0, 15)), 1'($urandom));
                end
                default: idle(int'($urandom_range(1, 3)));
            endcase
        end
        scan_all();
        // reset in the middle of a conversion
        send_temp(85);
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        scan_all();
        chk("idle_after_reset", int'(bus.temp_ready), 1);
        pix(X0 + 50, Y0 + 20, 1);
        idle(2);
        chk("s1_drained", s1q.size(), 0);
        chk("text_drained", tq.size(), 1);
        chk("busy_drained", bq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/text_overlay_ctrl.md
Name: text_overlay_ctrl

Overview:
- Sequences the 8x16 font ROM (5-bit character code, 4-bit row, 3-bit column, 1-bit pixel return) for the VGA temperature display.
- Holds a 2-row x 16-column character buffer, writable by the system controller.
- Converts binary temperature updates into two digit cells.
- Walks the pixel coordinates through a 2-stage pipeline to produce a registered text pixel for the RGB mux.

Parameters:
- X0, 10'd256, left pixel column of the text window (multiple of 8).
- Y0, 10'd208, top pixel row of the text window (multiple of 16).
- TEMP_ROW, 1'd1, buffer row receiving converted temperature digits.
- TEMP_COL, 4'd6, buffer column of the tens digit; units digit goes to TEMP_COL+1 (TEMP_COL <= 14).

Ports:
- clk, in, 1, system clock.
- rst_n, in, 1, asynchronous active-low reset.
- pix_tick, in, 1, pixel enable; the pipeline advances only when high.
- pixel_x, in, 10, current pixel column.
- pixel_y, in, 10, current pixel row.
- video_on, in, 1, visible area.
- wr_en, in, 1, buffer write strobe.
- wr_row, in, 1, buffer write row.
- wr_col, in, 4, buffer write column.
- wr_code, in, 5, buffer write character code.
- temp_valid, in, 1, temperature update valid.
- temp_in, in, 7, temperature, binary 0..127.
- temp_ready, out, 1, converter idle and able to accept an update.
- character_select, out, 5, code to font ROM.
- rom_addr, out, 4, glyph row to font ROM.
- rom_col, out, 3, glyph bit index to font ROM.
- rom_bit, in, 1, font ROM pixel (combinational return).
- text_on, out, 1, registered text pixel.

Behaviour:
- Reset: all 32 buffer cells = 5'd15 (blank), character_select = 15, rom_addr = 0, rom_col = 0, text_on = 0, FSM = IDLE, temp_ready = 1.
- Window: in_win = (pixel_x - X0) < 128 and (pixel_y - Y0) < 32, computed as unsigned 10-bit.
  - col = (pixel_x - X0)[6:3], row = (pixel_y - Y0)[4].
- Stage 1 (pix_tick):
  - character_select <= in_win ? buf[row][col] : 15.
  - rom_addr <= (pixel_y - Y0)[3:0].
  - rom_col <= 7 - (pixel_x - X0)[2:0]; glyph bit 7 is the leftmost pixel.
  - win_d1 <= in_win & video_on.
- Stage 2 (pix_tick): text_on <= rom_bit & win_d1.
- Latency is exactly 2 pix_ticks from coordinate to text_on. All stage registers hold while pix_tick = 0.
- Buffer write port: on wr_en, buf[wr_row][wr_col] <= wr_code. Writes occur every clk regardless of pix_tick. Codes 21..24 and 26..31 are stored as-is; the font renders them blank.
- Converter FSM:
  - IDLE: temp_ready = 1. On temp_valid, latch min(temp_in, 99) into acc, clear tens, go to CONV.
  - CONV: if acc >= 10, acc -= 10 and tens += 1; else go to WR. Maximum 9 subtract cycles.
  - WR: buf[TEMP_ROW][TEMP_COL] <= (tens == 0) ? 15 : tens, so a leading zero is blanked. buf[TEMP_ROW][TEMP_COL+1] <= acc[3:0]. Both cells are written in one cycle, then the FSM returns to IDLE.
- Handshake:
  - temp_valid while temp_ready = 0 is ignored and not queued.
  - Transfer occurs on temp_valid & temp_ready.
- Simultaneous writes: an FSM write and an external write to the same cell in the same cycle resolve to the FSM value. Writes to different cells both take effect.
- A write landing on the cell being displayed takes effect from the next stage-1 capture. Tearing within one glyph is acceptable.
- Reset mid-CONV or mid-WR returns to IDLE with a blank buffer; no partial digits remain.
- Coordinates outside the window (including x < X0 wrap-around in the subtraction) give character_select = 15 and text_on = 0.

Decomposition:
- Shared package/include (font_codes): character code constants (digits 0..9, D=10, T=11, E=12, M=13, P=14, BLANK=15, A=16, U=17, C=18, L=19, S=20, R=25), glyph geometry (8x16), window size (16x2), FSM state encodings.
- One natural sub-module: temp_bin2dig, the IDLE/CONV/WR converter with the valid/ready handshake, emitting two codes plus a write strobe into the buffer.
- The font ROM is instantiated alongside this block at the display top, not inside it.

Test Plan:
- Reset then scan the window with pix_tick = 1 -> text_on = 0 everywhere; character_select = 15; temp_ready = 1.
- Write code 11 (T) to row 0 col 0, scan pixel (X0+2, Y0+1) -> character_select = 11, rom_addr = 1, rom_col = 5; text_on = 1 two ticks later (glyph row 1 = 11111110).
- temp_in = 47 with temp_valid for 1 cycle -> temp_ready low for 6 cycles (4 CONV subtracts, 1 exit, 1 WR); cells (1,6) = 4 and (1,7) = 7.
- temp_in = 5, then temp_in = 120 -> first gives cells 15, 5; second saturates to 9, 9. A temp_valid pulse during CONV leaves the buffer unchanged.
- External wr_en to (1,6) with code 2 in the same cycle as FSM WR -> cell holds the FSM tens value.
- Assert rst_n = 0 mid-CONV, then scan -> buffer blank, FSM IDLE. Toggle pix_tick = 0 for 3 cycles mid-glyph -> text_on and ROM outputs hold their values.
